// File: rtl/reg_inuse_ctrl_pkg.sv
// Shared types and constants for the register in-use scoreboard controller.
// The configuration default and the FSM state enum each live in their own package.
package cva5_config;
    localparam int CLEAR_CYCLES_DEFAULT = 32;
endpackage

package cva5_types;
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } inuse_state_t;
endpackage

package reg_inuse_ctrl_pkg;
    localparam int RD_ADDR_W = 5;
    localparam int CLR_CNT_W = 5;

    // Index width for an N-entry selector, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/reg_inuse_ctrl_rr_retire_arbiter.sv
// Round-robin one-hot arbiter for the retire ports; priority starts at the
// port after the most recent grant and holds when nothing is granted.
module rr_retire_arbiter
    import reg_inuse_ctrl_pkg::*;
#(
    parameter int  NUM_REQ = 2,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);
    localparam logic [IDX_W:0]   NUM_W    = (IDX_W + 1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] ptr_next;
    logic [IDX_W:0]   sum;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        sum       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_reg} + (IDX_W + 1)'(k);
            if (sum >= NUM_W) begin
                sum = sum - NUM_W;
            end
            if (!grant_any && req[sum[IDX_W-1:0]]) begin
                grant_any                = 1'b1;
                grant[sum[IDX_W-1:0]]    = 1'b1;
                grant_idx                = sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (grant_any) begin
            ptr_reg <= ptr_next;
        end
    end
endmodule

// File: rtl/reg_inuse_ctrl.sv
// Sequences clear/run/drain for the register in-use scoreboard and forwards
// issue and round-robin-arbitrated retire events straight to its ports.
module reg_inuse_ctrl
    import cva5_config::*;
    import cva5_types::*;
    import reg_inuse_ctrl_pkg::*;
#(
    parameter int CLEAR_CYCLES  = CLEAR_CYCLES_DEFAULT,
    parameter int NUM_RETIRE    = 2,
    parameter int OUTSTANDING_W = 6
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush_req,
    input  logic                                  issue_valid,
    input  logic [RD_ADDR_W-1:0]                  issue_rd_addr,
    output logic                                  issue_ready,
    input  logic [NUM_RETIRE-1:0]                 ret_valid,
    input  logic [NUM_RETIRE-1:0][RD_ADDR_W-1:0]  ret_rd_addr,
    output logic [NUM_RETIRE-1:0]                 ret_ready,
    output logic                                  clr,
    output logic                                  issued,
    output logic [RD_ADDR_W-1:0]                  issued_rd_addr,
    output logic                                  retired,
    output logic [RD_ADDR_W-1:0]                  retired_rd_addr,
    output logic                                  busy
);
    localparam int                     IDX_W    = idx_width(NUM_RETIRE);
    localparam logic [CLR_CNT_W-1:0]   CLR_LAST = CLR_CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [OUTSTANDING_W-1:0] OUT_MAX = '1;

    inuse_state_t               state_reg;
    logic [CLR_CNT_W-1:0]       clr_cnt_reg;
    logic [OUTSTANDING_W-1:0]   outstanding_reg;

    logic                       retire_en;
    logic [NUM_RETIRE-1:0]      arb_req;
    logic [NUM_RETIRE-1:0]      grant;
    logic [IDX_W-1:0]           grant_idx;
    logic                       grant_any;

    assign retire_en = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);

    generate
        for (genvar gi = 0; gi < NUM_RETIRE; gi++) begin : g_req
            assign arb_req[gi] = ret_valid[gi] & retire_en;
        end
    endgenerate

    rr_retire_arbiter #(
        .NUM_REQ   (NUM_RETIRE)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (arb_req),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // A flush in the same cycle as an issue wins: the issue is refused.
    assign issue_ready     = (state_reg == ST_RUN) & ~flush_req;
    assign issued          = issue_valid & issue_ready;
    assign issued_rd_addr  = issue_rd_addr;
    assign ret_ready       = grant;
    assign retired         = grant_any;
    assign retired_rd_addr = grant_any ? ret_rd_addr[grant_idx] : '0;
    assign clr             = (state_reg == ST_CLEAR);
    assign busy            = (state_reg != ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_CLEAR;
            clr_cnt_reg     <= '0;
            outstanding_reg <= '0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    if (clr_cnt_reg == CLR_LAST) begin
                        clr_cnt_reg <= '0;
                        state_reg   <= ST_RUN;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (flush_req) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (outstanding_reg == '0) begin
                        state_reg <= ST_CLEAR;
                    end
                end
                default: begin
                    state_reg   <= ST_CLEAR;
                    clr_cnt_reg <= '0;
                end
            endcase

            // Saturate instead of wrapping; the illegal cases are flagged below.
            if (issued && !retired && outstanding_reg != OUT_MAX) begin
                outstanding_reg <= outstanding_reg + 1'b1;
            end else if (retired && !issued && outstanding_reg != '0) begin
                outstanding_reg <= outstanding_reg - 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(issued && !retired && outstanding_reg == OUT_MAX));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(retired && !issued && outstanding_reg == '0));
`endif
endmodule

// File: tb/tb_reg_inuse_ctrl.sv
// Self-checking bench for reg_inuse_ctrl: table-driven RUN vectors with an
// issue/retire scoreboard, plus hand sequences for reset, drain and clear.
module tb_reg_inuse_ctrl;
    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 flush_req = 1'b0;
    logic                 issue_valid = 1'b0;
    logic [4:0]           issue_rd_addr = '0;
    logic                 issue_ready;
    logic [1:0]           ret_valid = '0;
    logic [1:0][4:0]      ret_rd_addr = '0;
    logic [1:0]           ret_ready;
    logic                 clr;
    logic                 issued;
    logic [4:0]           issued_rd_addr;
    logic                 retired;
    logic [4:0]           retired_rd_addr;
    logic                 busy;

    reg_inuse_ctrl #(
        .CLEAR_CYCLES    (32),
        .NUM_RETIRE      (2),
        .OUTSTANDING_W   (6)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_req       (flush_req),
        .issue_valid     (issue_valid),
        .issue_rd_addr   (issue_rd_addr),
        .issue_ready     (issue_ready),
        .ret_valid       (ret_valid),
        .ret_rd_addr     (ret_rd_addr),
        .ret_ready       (ret_ready),
        .clr             (clr),
        .issued          (issued),
        .issued_rd_addr  (issued_rd_addr),
        .retired         (retired),
        .retired_rd_addr (retired_rd_addr),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [4:0] ia;
        logic [1:0] rv;
        logic [4:0] r0;
        logic [4:0] r1;
        logic       e_iss;
        logic       e_ret;
        logic [4:0] e_raddr;
        logic [1:0] e_rdy;
    } vec_t;

    vec_t       vt[16];
    int         tests = 0;
    int         fails = 0;
    logic [4:0] iss_q[$];
    logic [4:0] ret_q[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One cycle: drive after the rising edge, return at the falling edge to sample.
    task automatic drive(input logic iv, input logic [4:0] ia, input logic [1:0] rv,
                         input logic [4:0] r0, input logic [4:0] r1, input logic fl);
        @(posedge clk);
        #1;
        issue_valid    = iv;
        issue_rd_addr  = ia;
        ret_valid      = rv;
        ret_rd_addr[0] = r0;
        ret_rd_addr[1] = r1;
        flush_req      = fl;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b0);
    endtask

    // Pops the scoreboard whenever the DUT reports an issue or retire event.
    task automatic sb_sample();
        logic [4:0] e;
        if (issued) begin
            if (iss_q.size() == 0) begin
                check("unexpected_issue", 1, 0);
            end else begin
                e = iss_q.pop_front();
                check("issued_rd_addr", int'(issued_rd_addr), int'(e));
                $display("[TB] issue rd=%0d expected %0d", issued_rd_addr, e);
            end
        end
        if (retired) begin
            if (ret_q.size() == 0) begin
                check("unexpected_retire", 1, 0);
            end else begin
                e = ret_q.pop_front();
                check("retired_rd_addr", int'(retired_rd_addr), int'(e));
                $display("[TB] retire rd=%0d ready=%b expected %0d", retired_rd_addr, ret_ready, e);
            end
        end
    endtask

    // Counts consecutive clr cycles (start already seen); optional flush pulse inside.
    task automatic count_clr(input int start, input int flush_at, output int n);
        n = start;
        for (int g = 0; g < 100; g++) begin
            @(posedge clk);
            #1;
            flush_req = (flush_at > 0 && n == flush_at);
            @(negedge clk);
            if (!clr) break;
            n++;
        end
        flush_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clr"}, int'(clr), 1);
        check({tag, "_busy"}, int'(busy), 1);
        check({tag, "_issue_ready"}, int'(issue_ready), 0);
        check({tag, "_ret_ready"}, int'(ret_ready), 0);
        check({tag, "_issued"}, int'(issued), 0);
        check({tag, "_retired"}, int'(retired), 0);
    endtask

    initial begin
        int n;
        int waited;

        vt[0]  = '{1'b1, 5'd5,  2'b00, 5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  2'b00};
        vt[1]  = '{1'b1, 5'd6,  2'b00, 5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  2'b00};
        vt[2]  = '{1'b1, 5'd8,  2'b00, 5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  2'b00};
        vt[3]  = '{1'b1, 5'd10, 2'b00, 5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  2'b00};
        vt[4]  = '{1'b0, 5'd0,  2'b11, 5'd3,  5'd7,  1'b0, 1'b1, 5'd3,  2'b01};
        vt[5]  = '{1'b0, 5'd0,  2'b11, 5'd3,  5'd7,  1'b0, 1'b1, 5'd7,  2'b10};
        vt[6]  = '{1'b0, 5'd0,  2'b11, 5'd3,  5'd7,  1'b0, 1'b1, 5'd3,  2'b01};
        vt[7]  = '{1'b0, 5'd0,  2'b11, 5'd3,  5'd7,  1'b0, 1'b1, 5'd7,  2'b10};
        vt[8]  = '{1'b1, 5'd9,  2'b01, 5'd9,  5'd0,  1'b1, 1'b1, 5'd9,  2'b01};
        vt[9]  = '{1'b1, 5'd12, 2'b10, 5'd0,  5'd12, 1'b1, 1'b1, 5'd12, 2'b10};
        vt[10] = '{1'b1, 5'd2,  2'b00, 5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  2'b00};
        vt[11] = '{1'b0, 5'd0,  2'b10, 5'd0,  5'd2,  1'b0, 1'b1, 5'd2,  2'b10};
        vt[12] = '{1'b1, 5'd4,  2'b01, 5'd4,  5'd0,  1'b1, 1'b1, 5'd4,  2'b01};
        vt[13] = '{1'b0, 5'd0,  2'b00, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  2'b00};
        vt[14] = '{1'b1, 5'd1,  2'b11, 5'd1,  5'd1,  1'b1, 1'b1, 5'd1,  2'b10};
        vt[15] = '{1'b1, 5'd3,  2'b11, 5'd20, 5'd21, 1'b1, 1'b1, 5'd20, 2'b01};

        // Reset with requests pending: everything must stay gated.
        #2;
        rst_n       = 1'b0;
        issue_valid = 1'b1;
        ret_valid   = 2'b11;
        @(negedge clk);
        check_reset_outputs("in_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        issue_valid = 1'b0;
        ret_valid   = 2'b00;
        @(negedge clk);
        check_reset_outputs("after_release");
        count_clr(1, 0, n);
        check("initial_clr_cycles", n, 32);
        check("busy_after_clear", int'(busy), 0);

        // Table vectors in RUN.
        for (int i = 0; i < 16; i++) begin
            if (vt[i].e_iss) iss_q.push_back(vt[i].ia);
            if (vt[i].e_ret) ret_q.push_back(vt[i].e_raddr);
            drive(vt[i].iv, vt[i].ia, vt[i].rv, vt[i].r0, vt[i].r1, 1'b0);
            $display("[TB] vec %0d iv=%0d rv=%b issued=%0d retired=%0d ready=%b",
                     i, vt[i].iv, vt[i].rv, issued, retired, ret_ready);
            check("vec_issue_ready", int'(issue_ready), 1);
            check("vec_issued", int'(issued), int'(vt[i].e_iss));
            check("vec_retired", int'(retired), int'(vt[i].e_ret));
            check("vec_ret_ready", int'(ret_ready), int'(vt[i].e_rdy));
            sb_sample();
        end

        // Three issues, flush, drain held open until three retires.
        for (int k = 0; k < 3; k++) begin
            iss_q.push_back(5'(11 + k));
            drive(1'b1, 5'(11 + k), 2'b00, 5'd0, 5'd0, 1'b0);
            check("pre_flush_issued", int'(issued), 1);
            sb_sample();
        end
        drive(1'b1, 5'd13, 2'b00, 5'd0, 5'd0, 1'b1);
        check("flush_cycle_issue_ready", int'(issue_ready), 0);
        check("flush_cycle_issued", int'(issued), 0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd14, 2'b00, 5'd0, 5'd0, 1'b0);
            $display("[TB] drain wait %0d busy=%0d clr=%0d", k, busy, clr);
            check("drain_issue_ready", int'(issue_ready), 0);
            check("drain_issued", int'(issued), 0);
            check("drain_busy", int'(busy), 1);
            check("drain_clr", int'(clr), 0);
        end
        for (int k = 0; k < 3; k++) begin
            ret_q.push_back(5'(11 + k));
            drive(1'b0, 5'd0, 2'b01, 5'(11 + k), 5'd0, 1'b0);
            check("drain_retired", int'(retired), 1);
            check("drain_ret_ready", int'(ret_ready), 1);
            sb_sample();
        end
        waited = 0;
        while (waited < 4) begin
            idle();
            waited++;
            if (clr) break;
        end
        check("clear_after_drain", int'(clr), 1);
        check("drain_exit_latency_ok", int'(waited <= 2), 1);
        count_clr(1, 0, n);
        check("drain_clr_cycles", n, 32);

        // Flush with nothing outstanding; a second flush during CLEAR is ignored.
        drive(1'b0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1);
        check("flush0_issue_ready", int'(issue_ready), 0);
        idle();
        check("flush0_drain_clr", int'(clr), 0);
        check("flush0_drain_busy", int'(busy), 1);
        idle();
        check("flush0_clear_start", int'(clr), 1);
        count_clr(1, 5, n);
        check("flush0_clr_cycles", n, 32);
        check("flush0_busy_after", int'(busy), 0);

        // Reset pulse at clear count 17 restarts the full sequence.
        drive(1'b0, 5'd0, 2'b00, 5'd0, 5'd0, 1'b1);
        idle();
        idle();
        check("rst17_clear_start", int'(clr), 1);
        for (int k = 1; k < 17; k++) idle();
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        issue_valid = 1'b1;
        ret_valid   = 2'b11;
        @(negedge clk);
        check_reset_outputs("mid_clear_reset");
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        issue_valid = 1'b0;
        ret_valid   = 2'b00;
        @(negedge clk);
        check_reset_outputs("mid_clear_release");
        count_clr(1, 0, n);
        check("rst17_clr_cycles", n, 32);

        check("issue_queue_drained", iss_q.size(), 0);
        check("retire_queue_drained", ret_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
